// File: rtl/race_pkg.sv
// race_pkg: shared state encodings and BCD constants for the race score keeper.
package race_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;
    localparam logic [15:0] BCD_MAX = 16'h9999;
    localparam int DIGIT_W = 4;
endpackage

// File: rtl/bcd4_add_sat.sv
// bcd4_add_sat: 4-digit BCD add of a 0-2 increment, saturating at 9999.
module bcd4_add_sat
    import race_pkg::*;
(
    input  logic [15:0] val,
    input  logic [1:0]  inc,
    output logic [15:0] sum
);
    logic [4:0]  c;
    logic [4:0]  t;
    logic [15:0] s;
    always_comb begin
        c = {3'b0, inc};
        t = '0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            t = {1'b0, val[DIGIT_W*i +: DIGIT_W]} + c;
            s[DIGIT_W*i +: DIGIT_W] = (t > 5'd9) ? t[3:0] - 4'd10 : t[3:0];
            c = (t > 5'd9) ? 5'd1 : 5'd0;
        end
        // a carry out of the thousands digit means the true sum passed 9999
        sum = (c != 5'd0) ? BCD_MAX : s;
    end
endmodule

// File: rtl/race_score_bcd.sv
// race_score_bcd: run/over FSM, survival tick counter, BCD score and session high score.
module race_score_bcd
    import race_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        crash,
    input  logic        point,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic        running,
    output logic        game_over,
    output logic        new_high
);
    localparam int CW = $clog2(TICK_CYCLES);
    state_t          state_q, state_d;
    logic [15:0]     score_q, score_d, hi_q, hi_d, sum;
    logic [CW-1:0]   tick_q, tick_d;
    logic            new_high_q, new_high_d, tick;
    logic [1:0]      inc;
    assign tick = (state_q == RUN) && (tick_q == CW'(TICK_CYCLES - 1));
    assign inc  = {point & tick, point ^ tick};
    bcd4_add_sat u_add (.val(score_q), .inc(inc), .sum(sum));
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        hi_d       = hi_q;
        tick_d     = tick_q;
        new_high_d = 1'b0;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                score_d = '0;
                tick_d  = '0;
            end
        end else if (crash) begin
            // crash wins over a same-cycle increment; compare the pre-increment score
            state_d = OVER;
            if (score_q > hi_q) begin
                hi_d       = score_q;
                new_high_d = 1'b1;
            end
        end else begin
            score_d = sum;
            tick_d  = tick ? '0 : tick_q + CW'(1);
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            score_q    <= '0;
            hi_q       <= '0;
            tick_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            hi_q       <= hi_d;
            tick_q     <= tick_d;
            new_high_q <= new_high_d;
        end
    end
    assign score     = score_q;
    assign hi_score  = hi_q;
    assign running   = (state_q == RUN);
    assign game_over = (state_q == OVER);
    assign new_high  = new_high_q;
endmodule

// File: tb/tb_race_score_bcd.sv
// tb_race_score_bcd: table vectors plus a decimal reference model feeding a scoreboard queue.
module tb_race_score_bcd;
    localparam int T = 4;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, crash = 1'b0, point = 1'b0;
    logic [15:0] score, hi_score;
    logic        running, game_over, new_high;
    race_score_bcd #(.TICK_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .start(start), .crash(crash), .point(point),
        .score(score), .hi_score(hi_score), .running(running),
        .game_over(game_over), .new_high(new_high)
    );
    always #5 clock = ~clock;
    typedef struct packed {
        logic [15:0] sc;
        logic [15:0] hi;
        logic        r;
        logic        g;
        logic        nh;
    } obs_t;
    typedef struct {
        logic s;
        logic c;
        logic p;
        obs_t e;
    } vec_t;
    obs_t exp_q[$];
    vec_t tbl[26];
    int   n_cmp = 0, n_fail = 0;
    int   m_state = 0, m_score = 0, m_hi = 0, m_tick = 0;
    logic m_nh = 1'b0;
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    function automatic obs_t dut_obs();
        return {score, hi_score, running, game_over, new_high};
    endfunction
    function automatic obs_t model_obs();
        return {to_bcd(m_score), to_bcd(m_hi), m_state == 1, m_state == 2, m_nh};
    endfunction
    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got score=%h hi=%h run=%b over=%b nh=%b, want score=%h hi=%h run=%b over=%b nh=%b",
                     name, got.sc, got.hi, got.r, got.g, got.nh, want.sc, want.hi, want.r, want.g, want.nh);
        end
    endtask
    task automatic step(input logic s, input logic c, input logic p);
        bit tk;
        start = s; crash = c; point = p;
        m_nh = 1'b0;
        tk = (m_state == 1) && (m_tick == T - 1);
        if (m_state != 1) begin
            if (s) begin m_state = 1; m_score = 0; m_tick = 0; end
        end else if (c) begin
            m_state = 2;
            if (m_score > m_hi) begin m_hi = m_score; m_nh = 1'b1; end
        end else begin
            m_tick  = tk ? 0 : m_tick + 1;
            m_score = m_score + int'(p) + int'(tk);
            if (m_score > 9999) m_score = 9999;
        end
        exp_q.push_back(model_obs());
        @(posedge clock);
        #1;
        start = 1'b0; crash = 1'b0; point = 1'b0;
        check("scoreboard", dut_obs(), exp_q.pop_front());
    endtask
    function automatic bit tick_next();
        return (m_state == 1) && (m_tick == T - 1);
    endfunction
    initial begin
        bit tk;
        logic [15:0] want;
        tbl[0]  = '{1'b0, 1'b1, 1'b0, {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, {16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0}};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, {16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, {16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, {16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, {16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, {16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, {16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0}};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, {16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1}};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, {16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0}};
        tbl[10] = '{1'b0, 1'b1, 1'b0, {16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0}};
        tbl[11] = '{1'b1, 1'b0, 1'b1, {16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[12] = '{1'b0, 1'b0, 1'b1, {16'h0001, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[13] = '{1'b0, 1'b0, 1'b1, {16'h0002, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[14] = '{1'b0, 1'b0, 1'b1, {16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[15] = '{1'b0, 1'b0, 1'b0, {16'h0004, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[16] = '{1'b0, 1'b0, 1'b1, {16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[17] = '{1'b0, 1'b1, 1'b0, {16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0}};
        tbl[18] = '{1'b1, 1'b0, 1'b0, {16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[19] = '{1'b0, 1'b0, 1'b1, {16'h0001, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[20] = '{1'b0, 1'b0, 1'b1, {16'h0002, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[21] = '{1'b0, 1'b0, 1'b1, {16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[22] = '{1'b0, 1'b0, 1'b1, {16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[23] = '{1'b0, 1'b0, 1'b1, {16'h0006, 16'h0005, 1'b1, 1'b0, 1'b0}};
        tbl[24] = '{1'b0, 1'b1, 1'b0, {16'h0006, 16'h0006, 1'b0, 1'b1, 1'b1}};
        tbl[25] = '{1'b0, 1'b0, 1'b0, {16'h0006, 16'h0006, 1'b0, 1'b1, 1'b0}};
        repeat (2) @(posedge clock);
        #1;
        check("reset_values", dut_obs(), '0);
        reset = 1'b0;
        #2;
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].c, tbl[i].p);
            check($sformatf("vec%0d", i), dut_obs(), tbl[i].e);
        end
        // climb to 0099 on points, then one more point carries into the hundreds
        step(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 200 && m_score < 99; n++) begin
            tk = tick_next();
            step(1'b0, 1'b0, (m_score + int'(tk)) < 99);
        end
        check("reach_0099", dut_obs(), {16'h0099, 16'h0006, 1'b1, 1'b0, 1'b0});
        want = tick_next() ? 16'h0101 : 16'h0100;
        step(1'b0, 1'b0, 1'b1);
        check("carry_0100", dut_obs(), {want, 16'h0006, 1'b1, 1'b0, 1'b0});
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (score[3:0] > 4'd9 || score[7:4] > 4'd9 || score[11:8] > 4'd9 || score[15:12] > 4'd9) begin
                n_fail++;
                $display("FAIL digit_range: got score=%h, want every digit 0-9", score);
            end
        end
        // saturation: sit at 9998 until a tick cycle, then point on top of the tick
        for (int n = 0; n < 20000 && m_score < 9999; n++) begin
            tk = tick_next();
            if (m_score == 9998) step(1'b0, 1'b0, tk);
            else step(1'b0, 1'b0, (m_score + int'(tk) + 1) <= 9998);
        end
        check("saturate_9999", dut_obs(), {16'h9999, 16'h0006, 1'b1, 1'b0, 1'b0});
        repeat (6) step(1'b0, 1'b0, 1'b1);
        check("stay_9999", dut_obs(), {16'h9999, 16'h0006, 1'b1, 1'b0, 1'b0});
        step(1'b0, 1'b1, 1'b1);
        check("crash_hi_9999", dut_obs(), {16'h9999, 16'h9999, 1'b0, 1'b1, 1'b1});
        // asynchronous reset mid-run at score 0037, observed before the next edge
        step(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 100 && m_score < 37; n++) begin
            tk = tick_next();
            step(1'b0, 1'b0, (m_score + int'(tk)) < 37);
        end
        check("reach_0037", dut_obs(), {16'h0037, 16'h9999, 1'b1, 1'b0, 1'b0});
        #2 reset = 1'b1;
        #1;
        check("async_reset", dut_obs(), '0);
        m_state = 0; m_score = 0; m_hi = 0; m_tick = 0; m_nh = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check("idle_after_reset", dut_obs(), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
